// File: rtl/edge_train_generator.sv
// Burst edge generator: accepts (num_edges, gap) on a valid/ready handshake and
// toggles signal_out num_edges times, one toggle every max(gap,1) cycles.
module edge_train_generator #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [CNT_W-1:0] num_edges,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             signal_out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [CNT_W-1:0] REM_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] REM_ZERO = '0;
    localparam logic [GAP_W-1:0] GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0] GAP_ZERO = '0;

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] rem_reg;
    logic [GAP_W-1:0] gap_reg;
    logic [GAP_W-1:0] cnt_reg;
    logic [GAP_W-1:0] gap_eff;
    logic             accept;

    assign start_ready = ~busy & ~abort;
    assign accept      = start_valid & start_ready;
    // A zero spacing would otherwise underflow the reload value.
    assign gap_eff     = (gap == GAP_ZERO) ? GAP_ONE : gap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            rem_reg    <= '0;
            gap_reg    <= '0;
            cnt_reg    <= '0;
            signal_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        rem_reg   <= num_edges;
                        gap_reg   <= gap_eff;
                        cnt_reg   <= gap_eff - GAP_ONE;
                        busy      <= 1'b1;
                        state_reg <= (num_edges != REM_ZERO) ? RUN : FIN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end else if (cnt_reg == GAP_ZERO) begin
                        signal_out <= ~signal_out;
                        rem_reg    <= rem_reg - REM_ONE;
                        cnt_reg    <= gap_reg - GAP_ONE;
                        // Completion lands on the same edge as the last toggle.
                        if (rem_reg == REM_ONE) begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - GAP_ONE;
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    done      <= ~abort;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
